product_accumulator: RTL and testbench

Sequential accumulate stage that sits directly downstream of the team's combinational 8x8 unsigned multiplier and consumes its 16-bit products. It sums a programmed number of products into a wide accumulator, accepting at most one product per cycle. It presents the finished sum, plus a sticky overflow flag, on a valid/ready output port. Typical use is dot products and FIR taps.

---
 rtl/product_accumulator.sv | 112 +++++++++++
 tb/tb_product_accumulator.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : product_accumulator
//  Brief    : Sums a programmed number of unsigned products into a wide
//             accumulator and presents the result, with a sticky carry-out
//             flag, on a valid/ready output port.
//  Revision : 1.0  initial release
// ============================================================================
module product_accumulator #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 20,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_overflow,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] c_one = LEN_W'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ACC_W-1:0]   r_acc;
    logic               r_overflow;
    logic [LEN_W-1:0]   r_remaining;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [ACC_W:0]     w_sum;

    // Handshake outputs are pure state decodes, so no input reaches them
    // combinationally.
    assign in_ready     = (r_state == S_ACCUM);
    assign out_valid    = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign out_sum      = r_acc;
    assign out_overflow = r_overflow;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(in_product);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_in_fire && (r_remaining == c_one)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (w_out_fire) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Accumulator datapath: cleared on start, updated only on a transfer,
    // left untouched on exit from DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_overflow  <= 1'b0;
            r_remaining <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_acc       <= '0;
                r_overflow  <= 1'b0;
                r_remaining <= len;
            end else if (w_in_fire) begin
                r_acc       <= w_sum[ACC_W-1:0];
                r_overflow  <= r_overflow | w_sum[ACC_W];
                r_remaining <= r_remaining - c_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_product_accumulator
//  Brief    : Self-checking bench for product_accumulator: directed vector
//             table, reset-abort sequence and randomized transactions
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_product_accumulator;

    localparam int PROD_W = 16;
    localparam int ACC_W  = 20;
    localparam int LEN_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_overflow;
    logic              busy;

    int checks = 0;
    int errors = 0;

    logic [PROD_W-1:0] pq[$];

    product_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .len          (len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_product   (in_product),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        int          base;
        int          step;
        int          gap;
        int          hold;
        logic [19:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_in_ready"},  64'(in_ready),     64'd0);
        chk({nm, "_out_valid"}, 64'(out_valid),    64'd0);
        chk({nm, "_out_sum"},   64'(out_sum),      64'd0);
        chk({nm, "_out_ovf"},   64'(out_overflow), 64'd0);
        chk({nm, "_busy"},      64'(busy),         64'd0);
    endtask

    // Runs one accumulation of pq[0..n-1]. gap<0 selects random bubbles.
    // hold is the number of DONE cycles with out_ready low, each pulsing start.
    task automatic run_txn(input string nm, input int n, input int gap, input int hold,
                           input logic [19:0] es, input logic eo);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
        if (n == 0) begin
            chk({nm, "_zero_in_ready"}, 64'(in_ready), 64'd0);
        end
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
            for (int b = 0; b < g; b++) begin
                in_valid   = 1'b0;
                in_product = PROD_W'($urandom);
                tick();
            end
            in_valid   = 1'b1;
            in_product = pq[i];
            tick();
            in_valid   = 1'b0;
            in_product = PROD_W'($urandom);
            if (i < n - 1) begin
                chk({nm, "_early_valid"}, 64'(out_valid), 64'd0);
            end
        end
        chk({nm, "_out_valid"}, 64'(out_valid),    64'd1);
        chk({nm, "_in_ready_done"}, 64'(in_ready), 64'd0);
        chk({nm, "_busy"},      64'(busy),         64'd1);
        chk({nm, "_sum"},       64'(out_sum),      64'(es));
        chk({nm, "_ovf"},       64'(out_overflow), 64'(eo));
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            len       = LEN_W'($urandom_range(1, 255));
            tick();
            start = 1'b0;
            chk({nm, "_hold_valid"}, 64'(out_valid),    64'd1);
            chk({nm, "_hold_sum"},   64'(out_sum),      64'(es));
            chk({nm, "_hold_ovf"},   64'(out_overflow), 64'(eo));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, "_idle_valid"}, 64'(out_valid), 64'd0);
        chk({nm, "_idle_busy"},  64'(busy),      64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        len        = '0;
        in_valid   = 1'b0;
        in_product = '0;
        out_ready  = 1'b0;

        vecs[0] = '{"basic",    3, 100,   100, 0, 0, 20'd600,    1'b0};
        vecs[1] = '{"bubbles",  4, 65025, 0,   2, 0, 20'd260100, 1'b0};
        vecs[2] = '{"overflow", 17, 65025, 0,  0, 0, 20'd56849,  1'b1};
        vecs[3] = '{"zerolen",  0, 0,     0,   0, 3, 20'd0,      1'b0};
        vecs[4] = '{"backpres", 2, 7,     2,   0, 5, 20'd16,     1'b0};

        tick();
        tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("post_reset");

        // Directed vector table.
        foreach (vecs[k]) begin
            pq.delete();
            for (int i = 0; i < vecs[k].n; i++) begin
                pq.push_back(PROD_W'(vecs[k].base + vecs[k].step * i));
            end
            run_txn(vecs[k].name, vecs[k].n, vecs[k].gap, vecs[k].hold,
                    vecs[k].exp_sum, vecs[k].exp_ovf);
        end

        // Reset in the middle of an accumulation discards the partial sum.
        start = 1'b1;
        len   = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid   = 1'b1;
            in_product = 16'd1000;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst_async");
        tick();
        chk_reset_outputs("midrst_held");
        rst_n = 1'b1;
        tick();
        chk_reset_outputs("midrst_release");
        pq.delete();
        pq.push_back(16'd42);
        run_txn("after_rst", 1, 0, 0, 20'd42, 1'b0);

        // Randomized transactions against the arithmetic model.
        for (int t = 0; t < 12; t++) begin
            int          n;
            longint      total;
            logic [19:0] es;
            logic        eo;
            n = int'($urandom_range(1, 40));
            pq.delete();
            total = 0;
            for (int i = 0; i < n; i++) begin
                logic [PROD_W-1:0] p;
                p = (t % 2 == 0) ? PROD_W'($urandom) : PROD_W'($urandom_range(60000, 65535));
                pq.push_back(p);
                total += longint'(p);
            end
            es = 20'(total % (64'd1 << ACC_W));
            eo = (total >= (64'd1 << ACC_W));
            run_txn($sformatf("rand%0d", t), n, -1, int'($urandom_range(0, 3)), es, eo);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
